// File: rtl/div.sv
// Sequential 32-bit divider: one restoring shift-subtract step per clock on operand
// magnitudes, then a fix-up cycle applies signs and selects quotient or remainder.
module div (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        signctl,
    input  logic        remainder_out,
    output logic [31:0] dout,
    output logic        drdy
);

    typedef enum logic [1:0] {
        S_RESET,
        S_LOAD,
        S_BUSY,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dvsr_q, dvsr_d;
    logic        negq_q, negq_d;
    logic        negr_q, negr_d;
    logic        selrem_q, selrem_d;
    logic        bzero_q, bzero_d;
    logic [31:0] dout_q, dout_d;
    logic        drdy_q, drdy_d;

    logic [32:0] trial;
    logic [31:0] q_fix;
    logic [31:0] r_fix;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvsr_d   = dvsr_q;
        negq_d   = negq_q;
        negr_d   = negr_q;
        selrem_d = selrem_q;
        bzero_d  = bzero_q;
        dout_d   = dout_q;
        drdy_d   = drdy_q;
        trial    = {rem_q, quo_q[31]} - {1'b0, dvsr_q};
        q_fix    = negq_q ? (32'd0 - quo_q) : quo_q;
        r_fix    = negr_q ? (32'd0 - rem_q) : rem_q;

        case (state_q)
            S_RESET: state_d = S_LOAD;
            S_LOAD: begin
                // 0x80000000 negates to itself, read as unsigned 2^31
                quo_d    = (signctl && a[31]) ? (32'd0 - a) : a;
                dvsr_d   = (signctl && b[31]) ? (32'd0 - b) : b;
                negq_d   = signctl & (a[31] ^ b[31]);
                negr_d   = signctl & a[31];
                selrem_d = remainder_out;
                bzero_d  = (b == '0);
                rem_d    = '0;
                cnt_d    = '0;
                state_d  = S_BUSY;
            end
            S_BUSY: begin
                if (cnt_q != 6'd32) begin
                    if (!trial[32]) begin
                        rem_d = trial[31:0];
                        quo_d = {quo_q[30:0], 1'b1};
                    end else begin
                        rem_d = {rem_q[30:0], quo_q[31]};
                        quo_d = {quo_q[30:0], 1'b0};
                    end
                    cnt_d = cnt_q + 6'd1;
                end else begin
                    // A zero divisor yields all-ones regardless of operand signs
                    dout_d  = selrem_q ? r_fix : (bzero_q ? '1 : q_fix);
                    drdy_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: state_d = S_DONE;
            default: state_d = S_RESET;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_RESET;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvsr_q   <= '0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            selrem_q <= 1'b0;
            bzero_q  <= 1'b0;
            dout_q   <= '0;
            drdy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvsr_q   <= dvsr_d;
            negq_q   <= negq_d;
            negr_q   <= negr_d;
            selrem_q <= selrem_d;
            bzero_q  <= bzero_d;
            dout_q   <= dout_d;
            drdy_q   <= drdy_d;
        end
    end

    assign dout = dout_q;
    assign drdy = drdy_q;

endmodule

// File: tb/tb_div.sv
// Randomized and directed checks of div against a plain-arithmetic reference,
// including reset clearing, result hold, input isolation and mid-operation abort.
module tb_div;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic        signctl;
    logic        remainder_out;
    logic [31:0] dout;
    logic        drdy;

    int unsigned n_chk = 0;
    int unsigned n_bad = 0;

    div dut (
        .clk           (clk),
        .rst           (rst),
        .a             (a),
        .b             (b),
        .signctl       (signctl),
        .remainder_out (remainder_out),
        .dout          (dout),
        .drdy          (drdy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_div(input logic [31:0] x, input logic [31:0] y,
                                            input logic sc, input logic ro);
        logic [31:0] q;
        logic [31:0] r;
        int          sx;
        int          sy;
        if (y == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = x;
        end else if (!sc) begin
            q = x / y;
            r = x % y;
        end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else begin
            sx = $signed(x);
            sy = $signed(y);
            q = 32'(sx / sy);
            r = 32'(sx % sy);
        end
        return ro ? r : q;
    endfunction

    task automatic scramble();
        a             = $urandom;
        b             = $urandom;
        signctl       = 1'($urandom);
        remainder_out = 1'($urandom);
    endtask

    // Called and returns at 1 time unit after a rising edge.
    task automatic do_reset();
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_dout", dout, 32'd0);
        check("rst_drdy", {31'd0, drdy}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic sc,
                          input logic ro, input logic [31:0] exp, input string tag);
        int n;
        int i;
        do_reset();
        a             = x;
        b             = y;
        signctl       = sc;
        remainder_out = ro;
        rst           = 1'b1;
        n = 0;
        i = 0;
        while (n == 0 && i < 40) begin
            i++;
            @(posedge clk);
            #1;
            if (i == 2) scramble();
            if (drdy) n = i;
        end
        check("drdy_within_35", {31'd0, (n > 0 && n <= 35)}, 32'd1);
        check(tag, dout, exp);
        scramble();
        repeat (3) @(posedge clk);
        #1;
        check("hold_dout", dout, exp);
        check("hold_drdy", {31'd0, drdy}, 32'd1);
    endtask

    task automatic run_rand(input logic [31:0] x, input logic [31:0] y, input logic sc,
                            input logic ro);
        run_op(x, y, sc, ro, ref_div(x, y, sc, ro), "rand_result");
    endtask

    task automatic abort_at(input int edges);
        do_reset();
        scramble();
        rst = 1'b1;
        repeat (edges) @(posedge clk);
        #1;
        check("pre_abort_drdy", {31'd0, drdy}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("abort_dout", dout, 32'd0);
        check("abort_drdy", {31'd0, drdy}, 32'd0);
    endtask

    logic [31:0] pa;
    logic [31:0] pb;

    initial begin
        rst           = 1'b0;
        a             = '0;
        b             = '0;
        signctl       = 1'b0;
        remainder_out = 1'b0;
        @(posedge clk);
        #1;

        run_op(32'h0000_0007, 32'h0000_0002, 1'b0, 1'b0, 32'h0000_0003, "u_7_2_q");
        run_op(32'h0000_0007, 32'h0000_0002, 1'b0, 1'b1, 32'h0000_0001, "u_7_2_r");
        run_op(32'hFFFF_FFF9, 32'h0000_0002, 1'b1, 1'b0, 32'hFFFF_FFFD, "s_m7_2_q");
        run_op(32'hFFFF_FFF9, 32'h0000_0002, 1'b1, 1'b1, 32'hFFFF_FFFF, "s_m7_2_r");
        run_op(32'hF000_000F, 32'h1000_0001, 1'b0, 1'b0, 32'h0000_000F, "u_hi_q");
        run_op(32'hF000_000F, 32'h1000_0001, 1'b0, 1'b1, 32'h0000_0000, "u_hi_r");
        // -268435441 / 268435457 truncates to 0 with the dividend as remainder
        run_op(32'hF000_000F, 32'h1000_0001, 1'b1, 1'b0, 32'h0000_0000, "s_hi_q");
        run_op(32'hF000_000F, 32'h1000_0001, 1'b1, 1'b1, 32'hF000_000F, "s_hi_r");
        run_op(32'h1234_5678, 32'h0000_0000, 1'b0, 1'b0, 32'hFFFF_FFFF, "u_dz_q");
        run_op(32'h1234_5678, 32'h0000_0000, 1'b0, 1'b1, 32'h1234_5678, "u_dz_r");
        run_op(32'h1234_5678, 32'h0000_0000, 1'b1, 1'b0, 32'hFFFF_FFFF, "s_dz_q");
        run_op(32'h1234_5678, 32'h0000_0000, 1'b1, 1'b1, 32'h1234_5678, "s_dz_r");
        run_op(32'h8000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'hFFFF_FFFF, "s_dzneg_q");
        run_op(32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1, 32'h8000_0000, "s_dzneg_r");
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h8000_0000, "s_ovf_q");
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h0000_0000, "s_ovf_r");
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0000_0000, "u_ovf_q");
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h8000_0000, "u_ovf_r");

        abort_at(10);
        run_op(32'h0000_0064, 32'h0000_0007, 1'b0, 1'b0, 32'h0000_000E, "post_abort_q");
        abort_at(1);
        run_op(32'hFFFF_FF9C, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, "post_abort_r");
        abort_at(34);
        run_op(32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, 1'b0, 32'h0000_000E, "post_abort_s");

        // Edge-bit patterns: random 4 MSBs and 4 LSBs with a zero middle
        for (int m = 0; m < 4; m++) begin
            for (int k = 0; k < 280; k++) begin
                pa = {4'($urandom), 24'd0, 4'($urandom)};
                pb = {4'($urandom), 24'd0, 4'($urandom)};
                run_rand(pa, pb, m[1], m[0]);
            end
        end

        for (int k = 0; k < 160; k++) begin
            pa = $urandom;
            pb = $urandom >> $urandom_range(31, 0);
            run_rand(pa, pb, 1'($urandom), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
        $finish;
    end

endmodule
